// File: rtl/spi_frame_rx_pkg.sv
// Shared constants, field positions and state encoding for the SPI frame receiver.
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 5;

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic [CNT_W-1:0]  CNT_FULL         = 5'd16;
    localparam logic [CNT_W-1:0]  CNT_SAT          = 5'd17;
    localparam logic [ADDR_W-1:0] MAX_ADDR_DEFAULT = 7'h04;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_EVAL  = 2'd2
    } rx_state_t;

    // Bit counter sticks at 17 so any over-long frame stays distinguishable from 16.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_SAT) ? cnt : cnt + 5'd1;
    endfunction

endpackage

// File: rtl/spi_frame_rx_if.sv
// Bundle of raw SPI pins and the decoded frame outputs towards the register bank.
interface spi_frame_rx_if;
    import spi_frame_pkg::*;

    logic              spi_sclk;
    logic              spi_copi;
    logic              spi_ncs;
    logic              frame_valid;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              frame_err;
    logic              busy;
    logic [7:0]        err_count;

    modport master (
        output spi_sclk, spi_copi, spi_ncs,
        input  frame_valid, frame_addr, frame_data, frame_err, busy, err_count
    );

    modport slave (
        input  spi_sclk, spi_copi, spi_ncs,
        output frame_valid, frame_addr, frame_data, frame_err, busy, err_count
    );

endinterface

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with registered rise/fall pulses.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    // Synchroniser chain, delay flop and edge pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {STAGES{RST_VAL}};
            prev_r <= RST_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
            rise_r <= sync_r[STAGES-1] & ~prev_r;
            fall_r <= ~sync_r[STAGES-1] & prev_r;
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI write-frame receiver: synchronises pins, deserialises 16-bit frames, validates them.
// Optional saturating error counter enabled by SPI_FRAME_RX_ERR_COUNT_EN.
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = MAX_ADDR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    spi_frame_rx_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = RX_IDLE;
    localparam logic [1:0] ST_SHIFT = RX_SHIFT;
    localparam logic [1:0] ST_EVAL  = RX_EVAL;

    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic copi_lvl_s, copi_rise_s, copi_fall_s;
    logic ncs_lvl_s,  ncs_rise_s,  ncs_fall_s;
    logic unused_edges_s;

    logic [1:0]            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic                  valid_r;
    logic                  err_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [DATA_W-1:0]     data_r;
    logic                  busy_r;
    logic [SYNC_STAGES:0]  warm_r;
    logic                  armed_r;
    logic                  eval_valid_s;
    logic                  eval_err_s;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(bus.spi_sclk),
        .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(bus.spi_copi),
        .level(copi_lvl_s), .rise(copi_rise_s), .fall(copi_fall_s)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(bus.spi_ncs),
        .level(ncs_lvl_s), .rise(ncs_rise_s), .fall(ncs_fall_s)
    );

    assign unused_edges_s = ^{sclk_lvl_s, sclk_fall_s, copi_rise_s, copi_fall_s};

    // Frame acceptance decision, evaluated against the completed shift register.
    always_comb begin
        eval_valid_s = 1'b0;
        eval_err_s   = 1'b0;
        if (cnt_r == CNT_FULL) begin
            if (shift_r[RW_BIT]) begin
                if (shift_r[ADDR_MSB:ADDR_LSB] <= MAX_ADDR) begin
                    eval_valid_s = 1'b1;
                end else begin
                    eval_err_s = 1'b1;
                end
            end else begin
                eval_valid_s = 1'b0;
            end
        end else if (cnt_r != 5'd0) begin
            eval_err_s = 1'b1;
        end else begin
            eval_err_s = 1'b0;
        end
    end

    // Receive FSM, shifter, strobes and held frame fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 5'd0;
            shift_r <= 16'h0000;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= 7'h00;
            data_r  <= 8'h00;
            busy_r  <= 1'b0;
            warm_r  <= '0;
            armed_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= ~ncs_lvl_s;
            warm_r  <= {warm_r[SYNC_STAGES-1:0], 1'b1};
            // The chain resets to "nCS high", so only trust a high level once real samples fill it.
            if (warm_r[SYNC_STAGES] && ncs_lvl_s) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 5'd0;
                    if (ncs_fall_s && armed_r) begin
                        state_r <= ST_SHIFT;
                        shift_r <= 16'h0000;
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise_s) begin
                        state_r <= ST_EVAL;
                    end else if (sclk_rise_s) begin
                        shift_r <= {shift_r[FRAME_BITS-2:0], copi_lvl_s};
                        cnt_r   <= cnt_step(cnt_r);
                    end
                end
                ST_EVAL: begin
                    state_r <= ST_IDLE;
                    valid_r <= eval_valid_s;
                    err_r   <= eval_err_s;
                    if (eval_valid_s) begin
                        addr_r <= shift_r[ADDR_MSB:ADDR_LSB];
                        data_r <= shift_r[DATA_MSB:DATA_LSB];
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.frame_valid = valid_r;
    assign bus.frame_err   = err_r;
    assign bus.frame_addr  = addr_r;
    assign bus.frame_data  = data_r;
    assign bus.busy        = busy_r;

`ifdef SPI_FRAME_RX_ERR_COUNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of rejected frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= 8'h00;
        end else if (err_r && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end
    end

    assign bus.err_count = err_cnt_r;
`else
    assign bus.err_count = 8'h00;
`endif

endmodule
